// File: rtl/ef_window_stats.sv
// Per-window match-count delta recorder. Records queue in a small FIFO. Optional min/max tracking is enabled by defining EF_STATS_MINMAX_EN.
// Latency: a record is visible on o_valid right after the edge that captures the window's closing sample.
// Backpressure: o_valid/i_ready handshake. When the FIFO is full and nothing pops, the record is dropped and o_overflow sticks.

module ef_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop frees the slot this same edge, so a push into a full FIFO may proceed.
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module ef_window_stats #(
    parameter int          WINDOW_LEN = 1024,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] THRESH     = 32'd256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        valid_in,
    input  logic [31:0] match_count,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_delta,
    output logic [15:0] o_win_idx,
    output logic        o_alarm,
    output logic        o_overflow
`ifdef EF_STATS_MINMAX_EN
    ,
    output logic [31:0] o_min_delta,
    output logic [31:0] o_max_delta
`endif
);
    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [31:0] delta;
        logic [15:0] idx;
        logic        alarm;
    } rec_t;

    state_t      state;
    logic [31:0] baseline;
    logic [15:0] sample_cnt;
    logic [15:0] win_idx;
    logic [31:0] delta;
    logic        close;
    logic        pop;
    logic        fifo_empty;
    logic        fifo_full;
    rec_t        push_rec;
    rec_t        head_rec;

    assign delta    = match_count - baseline;
    assign close    = (state == RUN) && valid_in && (sample_cnt == 16'(WINDOW_LEN - 1));
    assign pop      = o_valid && i_ready;
    assign push_rec = '{delta: delta, idx: win_idx, alarm: (delta > THRESH)};

    ef_fifo #(
        .W     ($bits(rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .push     (close),
        .push_dat (push_rec),
        .pop      (pop),
        .head_dat (head_rec),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Outputs read zero whenever nothing is queued, so stale FIFO storage never leaks out.
    assign o_valid   = !fifo_empty;
    assign o_delta   = o_valid ? head_rec.delta : '0;
    assign o_win_idx = o_valid ? head_rec.idx   : '0;
    assign o_alarm   = o_valid && head_rec.alarm;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            baseline   <= '0;
            sample_cnt <= '0;
            win_idx    <= '0;
            o_overflow <= 1'b0;
        end else if (valid_in) begin
            case (state)
                IDLE: begin
                    baseline   <= match_count;
                    sample_cnt <= '0;
                    state      <= RUN;
                end
                RUN: begin
                    if (close) begin
                        baseline   <= match_count;
                        sample_cnt <= '0;
                        win_idx    <= win_idx + 16'd1;
                        if (fifo_full && !pop) o_overflow <= 1'b1;
                    end else begin
                        sample_cnt <= sample_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EF_STATS_MINMAX_EN
    logic        close_q;
    logic [31:0] delta_q;

    // Dropped windows still count toward min/max, hence tracking close rather than push.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            close_q     <= 1'b0;
            delta_q     <= '0;
            o_min_delta <= 32'hFFFF_FFFF;
            o_max_delta <= '0;
        end else begin
            close_q <= close;
            delta_q <= delta;
            if (close_q) begin
                if (delta_q < o_min_delta) o_min_delta <= delta_q;
                if (delta_q > o_max_delta) o_max_delta <= delta_q;
            end
        end
    end
`endif
endmodule
